// File: rtl/make_clock_bank_pkg.sv
// Shared helpers for the derived-clock bank: channel-index width derivation.
package make_clock_bank_pkg;

  // Width of a channel index, never narrower than one bit so a single-channel
  // bank still has a legal CFG_CH port.
  function automatic int chan_idx_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/make_clock_chan.sv
// One derived-clock channel: half-period counter with deferred half-period commit,
// plus a level-sensitive gate latch feeding the gated clock output.
module make_clock_chan #(
  parameter int   CNTW      = 8,
  parameter logic INIT_VAL  = 1'b0,
  parameter logic INIT_GATE = 1'b1,
  parameter int   INIT_HALF = 1
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            i_wr,
  input  logic [CNTW-1:0] i_half,
  input  logic            i_gate,
  input  logic            i_sync,
  output logic            o_clk,
  output logic            o_clk_val,
  output logic            o_cur_gate,
  output logic            o_new_gate,
  output logic            o_pending
);

  logic [CNTW-1:0] r_cnt;
  logic [CNTW-1:0] r_half;
  logic [CNTW-1:0] r_pend_half;
  logic            r_pending;
  logic            r_clk_val;
  logic            r_new_gate;
  logic            r_cur_gate;

  logic [CNTW-1:0] w_cnt_d;
  logic [CNTW-1:0] w_half_d;
  logic [CNTW-1:0] w_pend_half_d;
  logic [CNTW-1:0] w_commit_half;
  logic            w_pending_d;
  logic            w_clk_val_d;
  logic            w_running;
  logic            w_toggle;

  assign w_running     = (r_half != '0);
  assign w_toggle      = w_running && (r_cnt == r_half - CNTW'(1));
  assign w_commit_half = r_pending ? r_pend_half : r_half;

  always_comb begin
    w_cnt_d       = r_cnt;
    w_half_d      = r_half;
    w_pend_half_d = r_pend_half;
    w_pending_d   = r_pending;
    w_clk_val_d   = r_clk_val;

    if (i_sync) begin
      // A write alongside SYNC bypasses the pending stage entirely.
      w_half_d    = i_wr ? i_half : w_commit_half;
      w_pending_d = 1'b0;
      w_cnt_d     = '0;
      if (w_half_d != '0)
        w_clk_val_d = INIT_VAL;
    end else if (w_toggle) begin
      w_clk_val_d = ~r_clk_val;
      w_cnt_d     = '0;
      w_half_d    = w_commit_half;
      w_pending_d = 1'b0;
      if (i_wr) begin
        // A write landing on a toggle edge waits for the following edge,
        // unless that edge is the one that just stopped the channel.
        if (w_commit_half != '0) begin
          w_pend_half_d = i_half;
          w_pending_d   = 1'b1;
        end else begin
          w_half_d = i_half;
        end
      end
    end else if (w_running) begin
      w_cnt_d = r_cnt + CNTW'(1);
      if (i_wr) begin
        w_pend_half_d = i_half;
        w_pending_d   = 1'b1;
      end
    end else begin
      w_cnt_d = '0;
      if (i_wr)
        w_half_d = i_half;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of evaluation order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt       <= '0;
      r_half      <= CNTW'(INIT_HALF);
      r_pend_half <= '0;
      r_pending   <= 1'b0;
      r_clk_val   <= INIT_VAL;
      r_new_gate  <= INIT_GATE;
    end else begin
      r_cnt       <= w_cnt_d;
      r_half      <= w_half_d;
      r_pend_half <= w_pend_half_d;
      r_pending   <= w_pending_d;
      r_clk_val   <= w_clk_val_d;
      if (i_wr)
        r_new_gate <= i_gate;
    end
  end

  // NOTE: this is an intentional level-sensitive latch (clock-gating cell
  // stand-in). It opens only while the ungated clock is low, which matches
  // "CLK_OUT low" whenever the gate is on and also stops a re-enabled gate
  // from slicing into a high phase that is already under way.
  always_latch begin
    if (!RST_N)
      r_cur_gate <= INIT_GATE;
    else if (!r_clk_val)
      r_cur_gate <= r_new_gate;
  end

  assign o_clk      = r_clk_val & r_cur_gate;
  assign o_clk_val  = r_clk_val;
  assign o_cur_gate = r_cur_gate;
  assign o_new_gate = r_new_gate;
  assign o_pending  = r_pending;

endmodule

// File: rtl/make_clock_bank.sv
// Bank of NCH independently programmable, glitch-free gated clocks derived from CLK,
// with a register-style config port and a bank-wide phase-align SYNC.
module make_clock_bank
  import make_clock_bank_pkg::*;
#(
  parameter int   NCH       = 4,
  parameter int   CNTW      = 8,
  parameter logic INIT_VAL  = 1'b0,
  parameter logic INIT_GATE = 1'b1,
  parameter int   INIT_HALF = 1,
  localparam int  CHW       = chan_idx_width(NCH)
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            CFG_EN,
  input  logic [CHW-1:0]  CFG_CH,
  input  logic [CNTW-1:0] CFG_HALF,
  input  logic            CFG_GATE,
  output logic            CFG_RDY,
  input  logic            SYNC,
  output logic [NCH-1:0]  CLK_OUT,
  output logic [NCH-1:0]  CLK_VAL_OUT,
  output logic [NCH-1:0]  CLK_GATE_OUT,
  output logic [NCH-1:0]  COND_OUT
);

  logic [NCH-1:0] w_pending;
  logic [NCH-1:0] w_wr;
  logic           w_cfg_rdy;

  // Channel numbers at or above NCH are always ready and write nowhere.
  always_comb begin
    w_cfg_rdy = 1'b1;
    w_wr      = '0;
    for (int i = 0; i < NCH; i++) begin
      if (int'(CFG_CH) == i)
        w_cfg_rdy = ~w_pending[i];
    end
    for (int i = 0; i < NCH; i++) begin
      w_wr[i] = CFG_EN && w_cfg_rdy && (int'(CFG_CH) == i);
    end
  end

  assign CFG_RDY = w_cfg_rdy;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    make_clock_chan #(
      .CNTW      (CNTW),
      .INIT_VAL  (INIT_VAL),
      .INIT_GATE (INIT_GATE),
      .INIT_HALF (INIT_HALF)
    ) u_chan (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .i_wr       (w_wr[g]),
      .i_half     (CFG_HALF),
      .i_gate     (CFG_GATE),
      .i_sync     (SYNC),
      .o_clk      (CLK_OUT[g]),
      .o_clk_val  (CLK_VAL_OUT[g]),
      .o_cur_gate (CLK_GATE_OUT[g]),
      .o_new_gate (COND_OUT[g]),
      .o_pending  (w_pending[g])
    );
  end

endmodule

// File: tb/tb_make_clock_bank.sv
// Directed bench for make_clock_bank: stimulus pushes cycle-tagged expectations,
// a monitor pops and compares them on the falling edge (or on demand mid-cycle).
module tb_make_clock_bank;

  localparam int S_OUT  = 0;
  localparam int S_VAL  = 1;
  localparam int S_GATE = 2;
  localparam int S_COND = 3;
  localparam int S_RDY  = 4;

  typedef struct {
    int          cyc;   // -1 = compare on the next mid-cycle kick
    int          sig;
    logic [3:0]  mask;
    logic [3:0]  val;
    string       name;
  } exp_t;

  logic       CLK;
  logic       RST_N;
  logic       CFG_EN;
  logic [1:0] CFG_CH;
  logic [7:0] CFG_HALF;
  logic       CFG_GATE;
  logic       CFG_RDY;
  logic       SYNC;
  logic [3:0] CLK_OUT;
  logic [3:0] CLK_VAL_OUT;
  logic [3:0] CLK_GATE_OUT;
  logic [3:0] COND_OUT;

  exp_t q[$];
  int   cyc      = 0;
  int   base     = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  event ev_kick;

  make_clock_bank u_dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .CFG_EN       (CFG_EN),
    .CFG_CH       (CFG_CH),
    .CFG_HALF     (CFG_HALF),
    .CFG_GATE     (CFG_GATE),
    .CFG_RDY      (CFG_RDY),
    .SYNC         (SYNC),
    .CLK_OUT      (CLK_OUT),
    .CLK_VAL_OUT  (CLK_VAL_OUT),
    .CLK_GATE_OUT (CLK_GATE_OUT),
    .COND_OUT     (COND_OUT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [3:0] sample(input int sig);
    case (sig)
      S_OUT:   return CLK_OUT;
      S_VAL:   return CLK_VAL_OUT;
      S_GATE:  return CLK_GATE_OUT;
      S_COND:  return COND_OUT;
      S_RDY:   return {3'b000, CFG_RDY};
      default: return 4'b0000;
    endcase
  endfunction

  task automatic check(input string name, input logic [3:0] act,
                       input logic [3:0] exp, input logic [3:0] mask);
    n_checks++;
    if ((act & mask) !== (exp & mask)) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %b expected %b (mask %b)", name, cyc, act, exp, mask);
    end
  endtask

  // Monitor: compares every expectation due now; stale ones count as failures.
  initial begin
    forever begin
      @(negedge CLK or ev_kick);
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].cyc == cyc || q[i].cyc == -1) begin
          check(q[i].name, sample(q[i].sig), q[i].val, q[i].mask);
          q.delete(i);
        end else if (q[i].cyc < cyc) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s: due at cyc %0d, still unchecked at %0d", q[i].name, q[i].cyc, cyc);
          q.delete(i);
        end
      end
    end
  end

  task automatic expect_at(input int dly, input int sig, input logic [3:0] mask,
                           input logic [3:0] val, input string name);
    exp_t e;
    e.cyc  = (dly < 0) ? -1 : cyc + dly;
    e.sig  = sig;
    e.mask = mask;
    e.val  = val;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic wait_to(input int k);
    while (cyc < base + k) tick();
  endtask

  task automatic cfg(input logic en, input int ch, input int half, input logic gate);
    CFG_EN   = en;
    CFG_CH   = 2'(ch);
    CFG_HALF = 8'(half);
    CFG_GATE = gate;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time budget at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0;
    SYNC  = 1'b0;
    cfg(1'b0, 0, 0, 1'b0);

    // Reset state
    tick();
    expect_at(1, S_VAL,  4'hF, 4'h0, "rst_val");
    expect_at(1, S_OUT,  4'hF, 4'h0, "rst_out");
    expect_at(1, S_GATE, 4'hF, 4'hF, "rst_gate");
    expect_at(1, S_COND, 4'hF, 4'hF, "rst_cond");
    expect_at(1, S_RDY,  4'h1, 4'h1, "rst_rdy");
    tick();
    RST_N = 1'b1;
    base  = cyc;

    // All channels at half=1 -> CLK/2
    expect_at(1, S_VAL, 4'hF, 4'hF, "t1_val_hi");
    expect_at(1, S_OUT, 4'hF, 4'hF, "t1_out_hi");
    expect_at(1, S_RDY, 4'h1, 4'h1, "t1_rdy");
    expect_at(2, S_VAL, 4'hF, 4'h0, "t1_val_lo");
    expect_at(2, S_OUT, 4'hF, 4'h0, "t1_out_lo");
    expect_at(3, S_VAL, 4'hF, 4'hF, "t1_val_hi2");

    // Ch1 half=3 while running: pending through one toggle, then period 6
    wait_to(3);
    cfg(1'b1, 1, 3, 1'b1);
    expect_at(1, S_VAL, 4'h2, 4'h0, "t2_toggle_pend");
    expect_at(1, S_RDY, 4'h1, 4'h0, "t2_rdy_busy");
    expect_at(2, S_VAL, 4'h2, 4'h2, "t2_commit_edge");
    expect_at(2, S_RDY, 4'h1, 4'h1, "t2_rdy_free");
    expect_at(4, S_VAL, 4'h2, 4'h2, "t2_hold_hi");
    expect_at(5, S_VAL, 4'h2, 4'h0, "t2_fall");
    expect_at(5, S_VAL, 4'hD, 4'h0, "t2_others");
    expect_at(7, S_VAL, 4'h2, 4'h0, "t2_hold_lo");
    expect_at(8, S_VAL, 4'h2, 4'h2, "t2_rise");
    // Write while busy must be dropped, gate included
    wait_to(4);
    cfg(1'b1, 1, 7, 1'b0);
    expect_at(2, S_COND, 4'h2, 4'h2, "t6_busy_gate_ignored");
    wait_to(5);
    cfg(1'b0, 1, 0, 1'b1);

    // Ch2: first stretch to half=3, then gate off in the middle of a high phase
    wait_to(13);
    cfg(1'b1, 2, 3, 1'b1);
    expect_at(1, S_RDY, 4'h1, 4'h0, "t3_rdy_busy");
    expect_at(1, S_VAL, 4'h4, 4'h0, "t3_pre_lo");
    expect_at(2, S_VAL, 4'h4, 4'h4, "t3_commit_hi");
    expect_at(5, S_VAL, 4'h4, 4'h0, "t3_half3_fall");
    wait_to(14);
    cfg(1'b0, 2, 3, 1'b1);
    wait_to(16);
    cfg(1'b1, 2, 3, 1'b0);
    expect_at(1, S_COND, 4'h4, 4'h0, "t3_cond_off");
    expect_at(1, S_GATE, 4'h4, 4'h4, "t3_gate_held");
    expect_at(1, S_OUT,  4'h4, 4'h4, "t3_out_completes");
    expect_at(2, S_VAL,  4'h4, 4'h0, "t3_val_fall");
    expect_at(2, S_GATE, 4'h4, 4'h0, "t3_gate_fall");
    expect_at(2, S_OUT,  4'h4, 4'h0, "t3_out_fall");
    expect_at(5, S_VAL,  4'h4, 4'h4, "t3_val_rise");
    expect_at(5, S_OUT,  4'h4, 4'h0, "t3_out_gated");
    wait_to(17);
    cfg(1'b0, 2, 3, 1'b0);

    // Ch0 half=2, ch3 half=5, then SYNC
    wait_to(24);
    cfg(1'b1, 0, 2, 1'b1);
    wait_to(25);
    cfg(1'b1, 3, 5, 1'b1);
    wait_to(26);
    cfg(1'b0, 0, 0, 1'b1);
    wait_to(28);
    SYNC = 1'b1;
    expect_at(1, S_VAL, 4'hF, 4'b0000, "t4_sync_val");
    expect_at(1, S_OUT, 4'hF, 4'b0000, "t4_sync_out");
    expect_at(2, S_VAL, 4'hF, 4'b0000, "t4_val_c1");
    expect_at(3, S_VAL, 4'hF, 4'b0001, "t4_ch0_rise");
    expect_at(3, S_OUT, 4'hF, 4'b0001, "t4_out_c2");
    expect_at(4, S_VAL, 4'hF, 4'b0111, "t4_val_c3");
    expect_at(4, S_OUT, 4'hF, 4'b0011, "t4_out_c3");
    expect_at(5, S_VAL, 4'hF, 4'b0110, "t4_val_c4");
    expect_at(6, S_VAL, 4'hF, 4'b1110, "t4_ch3_rise");
    expect_at(6, S_OUT, 4'hF, 4'b1010, "t4_out_c5");
    expect_at(7, S_VAL, 4'hF, 4'b1001, "t4_val_c6");
    wait_to(29);
    SYNC = 1'b0;

    // Ch1 half=0: stops after its next toggle; then half=4 restarts at once
    wait_to(36);
    cfg(1'b1, 1, 0, 1'b1);
    expect_at(1, S_RDY, 4'h1, 4'h0, "t5_rdy_busy");
    expect_at(1, S_VAL, 4'h2, 4'h0, "t5_pre");
    expect_at(2, S_VAL, 4'h2, 4'h2, "t5_last_toggle");
    expect_at(2, S_RDY, 4'h1, 4'h1, "t5_rdy_free");
    expect_at(8, S_VAL, 4'h2, 4'h2, "t5_stopped_hold");
    wait_to(37);
    cfg(1'b0, 1, 0, 1'b1);
    wait_to(44);
    cfg(1'b1, 1, 4, 1'b1);
    expect_at(1, S_RDY, 4'h1, 4'h1, "t5_restart_no_pend");
    expect_at(1, S_VAL, 4'h2, 4'h2, "t5_restart_level");
    expect_at(4, S_VAL, 4'h2, 4'h2, "t5_restart_hold");
    expect_at(5, S_VAL, 4'h2, 4'h0, "t5_restart_toggle");
    wait_to(45);
    cfg(1'b0, 1, 4, 1'b1);

    // Async reset in the middle of ch0's high phase
    wait_to(50);
    expect_at(1, S_VAL, 4'h1, 4'h1, "t6_pre_high");
    wait_to(51);
    #1;
    RST_N = 1'b0;
    #1;
    expect_at(-1, S_VAL,  4'hF, 4'h0, "t6_rst_val");
    expect_at(-1, S_OUT,  4'hF, 4'h0, "t6_rst_out");
    expect_at(-1, S_GATE, 4'hF, 4'hF, "t6_rst_gate");
    expect_at(-1, S_COND, 4'hF, 4'hF, "t6_rst_cond");
    -> ev_kick;
    wait_to(53);
    RST_N = 1'b1;
    expect_at(1, S_VAL, 4'hF, 4'hF, "t6_resume_hi");
    expect_at(1, S_RDY, 4'h1, 4'h1, "t6_resume_rdy");
    expect_at(2, S_VAL, 4'hF, 4'h0, "t6_resume_lo");
    wait_to(57);

    foreach (q[i]) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: never compared (due cyc %0d)", q[i].name, q[i].cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
